// File: rtl/rv_instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : rv_instr_loader
// Brief    : Boot-time loader. Assembles a framed little-endian byte stream into
//            32-bit words, writes them into instruction memory and releases the
//            core once a frame with a valid XOR checksum has been loaded.
// Options  : define LDR_TIMEOUT_EN to enable the inter-byte idle timeout.
// Revision : 1.0 - initial release
// ============================================================================
module rv_instr_loader #(
    parameter int ADDR_W      = 16,
    parameter int BASE_ADDR   = 0,
    parameter int MAX_WORDS   = 1024,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              instr_wr_en,
    output logic [ADDR_W-1:0] instr_addr_in,
    output logic [31:0]       instr_in,
    output logic              core_run,
    output logic              busy,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [15:0]       words_loaded
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_LEN0 = 3'd1;
    localparam logic [2:0] c_ST_LEN1 = 3'd2;
    localparam logic [2:0] c_ST_DATA = 3'd3;
    localparam logic [2:0] c_ST_CSUM = 3'd4;
    localparam logic [2:0] c_ST_DONE = 3'd5;
    localparam logic [2:0] c_ST_ERR  = 3'd6;

    localparam logic [1:0] c_EC_NONE    = 2'b00;
    localparam logic [1:0] c_EC_LEN     = 2'b01;
    localparam logic [1:0] c_EC_CSUM    = 2'b10;
    localparam logic [1:0] c_EC_TIMEOUT = 2'b11;

    localparam logic [ADDR_W-1:0] c_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       c_MAX  = 32'(MAX_WORDS);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [1:0]        w_err_code_nxt;
    logic              w_load_start;
    logic              w_accept;
    logic              w_busy;
    logic              w_timeout;
    logic [15:0]       w_len;
    logic              w_len_too_big;
    logic              w_last_word;

    logic [15:0]       r_len;
    logic [7:0]        r_csum;
    logic [1:0]        r_byte_idx;
    logic [23:0]       r_asm;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic [15:0]       r_words;
    logic [1:0]        r_err_code;

    assign w_busy        = (r_state == c_ST_LEN0) || (r_state == c_ST_LEN1) ||
                           (r_state == c_ST_DATA) || (r_state == c_ST_CSUM);
    assign w_accept      = rx_valid & w_busy;
    assign w_len         = {rx_data, r_len[7:0]};
    assign w_len_too_big = ({16'd0, w_len} > c_MAX);
    assign w_last_word   = (r_words == (r_len - 16'd1));

`ifdef LDR_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [c_TO_W-1:0] r_idle_cnt;

    // Idle cycles since the last accepted byte while a frame is open.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if (!w_busy || w_accept) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + c_TO_W'(1);
        end
    end

    assign w_timeout = w_busy && !w_accept && (r_idle_cnt == c_TO_W'(TIMEOUT_CYC - 1));
`else
    localparam int c_unused_timeout = TIMEOUT_CYC;

    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_err_code_nxt = r_err_code;
        w_load_start   = 1'b0;
        rx_ready       = w_busy;
        busy           = w_busy;
        core_run       = (r_state == c_ST_DONE);
        err            = (r_state == c_ST_ERR);

        case (r_state)
            c_ST_IDLE, c_ST_DONE, c_ST_ERR: begin
                if (start) begin
                    w_state_nxt    = c_ST_LEN0;
                    w_err_code_nxt = c_EC_NONE;
                    w_load_start   = 1'b1;
                end
            end
            c_ST_LEN0: begin
                if (w_accept) begin
                    w_state_nxt = c_ST_LEN1;
                end
            end
            c_ST_LEN1: begin
                if (w_accept) begin
                    if (w_len == 16'd0) begin
                        w_state_nxt = c_ST_CSUM;
                    end else if (w_len_too_big) begin
                        w_state_nxt    = c_ST_ERR;
                        w_err_code_nxt = c_EC_LEN;
                    end else begin
                        w_state_nxt = c_ST_DATA;
                    end
                end
            end
            c_ST_DATA: begin
                if (w_accept && (r_byte_idx == 2'd3) && w_last_word) begin
                    w_state_nxt = c_ST_CSUM;
                end
            end
            c_ST_CSUM: begin
                if (w_accept) begin
                    if (rx_data == r_csum) begin
                        w_state_nxt = c_ST_DONE;
                    end else begin
                        w_state_nxt    = c_ST_ERR;
                        w_err_code_nxt = c_EC_CSUM;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        // An accepted byte always beats the idle timeout, since w_timeout requires !w_accept.
        if (w_timeout) begin
            w_state_nxt    = c_ST_ERR;
            w_err_code_nxt = c_EC_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len      <= '0;
            r_csum     <= '0;
            r_byte_idx <= '0;
            r_asm      <= '0;
            r_wr_en    <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_words    <= '0;
            r_err_code <= c_EC_NONE;
        end else begin
            r_wr_en    <= 1'b0;
            r_err_code <= w_err_code_nxt;

            if (w_load_start) begin
                r_len      <= '0;
                r_csum     <= '0;
                r_byte_idx <= '0;
                r_words    <= '0;
            end

            if (w_accept) begin
                r_csum <= r_csum ^ rx_data;
                case (r_state)
                    c_ST_LEN0: r_len[7:0]  <= rx_data;
                    c_ST_LEN1: r_len[15:8] <= rx_data;
                    c_ST_DATA: begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0:    r_asm[7:0]   <= rx_data;
                            2'd1:    r_asm[15:8]  <= rx_data;
                            2'd2:    r_asm[23:16] <= rx_data;
                            default: begin
                                // Final byte goes straight to the write port; r_words is the word index.
                                r_wr_en <= 1'b1;
                                r_data  <= {rx_data, r_asm};
                                r_addr  <= c_BASE + ADDR_W'({r_words, 2'b00});
                                r_words <= r_words + 16'd1;
                            end
                        endcase
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign instr_wr_en   = r_wr_en;
    assign instr_addr_in = r_addr;
    assign instr_in      = r_data;
    assign err_code      = r_err_code;
    assign words_loaded  = r_words;

endmodule
`default_nettype wire
